ex_csa_accum_resolve: RTL

//  Streaming accumulator: sums a sequence of WIDTH-bit operands in carry-save form, one per

---
 rtl/ex_csa_pkg.sv | 18 +
 rtl/ex_csa_row.sv | 24 ++
 rtl/ex_csa_accum_resolve.sv | 146 ++++++++++++++
 3 files changed

// File: rtl/ex_csa_pkg.sv
// Shared definitions for the carry-save streaming accumulator.
//   state_e    : controller states (2-bit)
//   DEF_WIDTH  : default operand/result width
//   DEF_CHUNK  : default number of bits resolved per cycle
//   CNT_MAX    : saturation limit of the operand counter
package ex_csa_pkg;

    localparam int         DEF_WIDTH = 64;
    localparam int         DEF_CHUNK = 16;
    localparam logic [7:0] CNT_MAX   = 8'hFF;

    typedef enum logic [1:0] {
        ST_ACCUM   = 2'd0,
        ST_RESOLVE = 2'd1,
        ST_DONE    = 2'd2
    } state_e;

endpackage

// File: rtl/ex_csa_row.sv
// Combinational WIDTH-bit 3:2 compressor row.
//   a, b, d : three addends
//   sum     : bitwise XOR of the addends
//   carry   : bitwise majority shifted up one place; the carry out of the MSB is
//             dropped so that sum + carry == a + b + d modulo 2^WIDTH
module ex_csa_row
    import ex_csa_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] sum,
    output logic [WIDTH-1:0] carry
);

    logic [WIDTH-1:0] maj;

    assign sum   = a ^ b ^ d;
    assign maj   = (a & b) | (a & d) | (b & d);
    assign carry = {maj[WIDTH-2:0], 1'b0};

endmodule

// File: rtl/ex_csa_accum_resolve.sv
// Streaming carry-save accumulator with chunked carry resolution.
// Operands are folded into a redundant sum/carry pair, one per accepted beat,
// with no carry propagation in the loop. A flush beat starts a resolve phase that
// adds the pair CHUNK bits per cycle (ripple carry held in a flop between chunks),
// after which the result is offered on a valid/ready output.
//   clock, reset        : rising-edge clock, asynchronous active-high reset
//   inValid/inReady     : operand handshake; inReady only while accumulating
//   inData              : operand
//   inClear             : drop accumulated state before adding this beat
//   inFlush             : this beat is the last operand; begin resolve
//   outValid/outReady   : result handshake
//   outData             : resolved sum modulo 2^WIDTH (holds last result when idle)
//   outCount            : operands summed, saturating at 255
// WIDTH must be a multiple of CHUNK.
module ex_csa_accum_resolve
    import ex_csa_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int CHUNK = DEF_CHUNK
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             inValid,
    output logic             inReady,
    input  logic [WIDTH-1:0] inData,
    input  logic             inClear,
    input  logic             inFlush,
    output logic             outValid,
    input  logic             outReady,
    output logic [WIDTH-1:0] outData,
    output logic [7:0]       outCount
);

    localparam int            NCHK   = WIDTH / CHUNK;
    localparam int            KW     = (NCHK > 1) ? $clog2(NCHK) : 1;
    localparam logic [KW-1:0] K_LAST = KW'(NCHK - 1);

    function automatic logic [7:0] sat_inc(input logic [7:0] v);
        return (v == CNT_MAX) ? CNT_MAX : v + 8'd1;
    endfunction

    state_e           state_q, state_d;
    logic [WIDTH-1:0] s_q, s_d;
    logic [WIDTH-1:0] c_q, c_d;
    logic [7:0]       cnt_q, cnt_d;
    logic [KW-1:0]    k_q, k_d;
    logic             cy_q, cy_d;
    logic [WIDTH-1:0] out_data_q, out_data_d;
    logic [7:0]       out_cnt_q, out_cnt_d;

    logic             accept;
    logic [WIDTH-1:0] base_s, base_c;
    logic [WIDTH-1:0] row_s, row_c;
    logic [CHUNK-1:0] s_chk, c_chk;
    logic [CHUNK:0]   chk_sum;

    assign inReady  = (state_q == ST_ACCUM);
    assign outValid = (state_q == ST_DONE);
    assign outData  = out_data_q;
    assign outCount = out_cnt_q;
    assign accept   = inValid & inReady;

    assign base_s = inClear ? '0 : s_q;
    assign base_c = inClear ? '0 : c_q;

    ex_csa_row #(.WIDTH(WIDTH)) u_row (
        .a     (base_s),
        .b     (base_c),
        .d     (inData),
        .sum   (row_s),
        .carry (row_c)
    );

    // Chunk adder: one CHUNK-wide slice of S + C plus the carry from the slice below.
    assign s_chk   = s_q[k_q*CHUNK +: CHUNK];
    assign c_chk   = c_q[k_q*CHUNK +: CHUNK];
    assign chk_sum = {1'b0, s_chk} + {1'b0, c_chk} + {{CHUNK{1'b0}}, cy_q};

    always_comb begin
        state_d    = state_q;
        s_d        = s_q;
        c_d        = c_q;
        cnt_d      = cnt_q;
        k_d        = k_q;
        cy_d       = cy_q;
        out_data_d = out_data_q;
        out_cnt_d  = out_cnt_q;
        case (state_q)
            ST_ACCUM: begin
                if (accept) begin
                    s_d   = row_s;
                    c_d   = row_c;
                    cnt_d = inClear ? 8'd1 : sat_inc(cnt_q);
                    if (inFlush) begin
                        state_d = ST_RESOLVE;
                        k_d     = '0;
                        cy_d    = 1'b0;
                    end
                end
            end
            ST_RESOLVE: begin
                // Resolved slices overwrite S in place; that slice of S is no longer needed.
                s_d[k_q*CHUNK +: CHUNK] = chk_sum[CHUNK-1:0];
                cy_d = chk_sum[CHUNK];
                k_d  = k_q + 1'b1;
                if (k_q == K_LAST) begin
                    state_d    = ST_DONE;
                    out_data_d = s_d;
                    out_cnt_d  = cnt_q;
                end
            end
            ST_DONE: begin
                if (outReady) begin
                    state_d = ST_ACCUM;
                    s_d     = '0;
                    c_d     = '0;
                    cnt_d   = 8'd0;
                end
            end
            default: state_d = ST_ACCUM;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q    <= ST_ACCUM;
            s_q        <= '0;
            c_q        <= '0;
            cnt_q      <= 8'd0;
            k_q        <= '0;
            cy_q       <= 1'b0;
            out_data_q <= '0;
            out_cnt_q  <= 8'd0;
        end else begin
            state_q    <= state_d;
            s_q        <= s_d;
            c_q        <= c_d;
            cnt_q      <= cnt_d;
            k_q        <= k_d;
            cy_q       <= cy_d;
            out_data_q <= out_data_d;
            out_cnt_q  <= out_cnt_d;
        end
    end

endmodule
